// File: rtl/data_mem_ctrl_if.sv
// Core/memory signal bundle for data_mem_ctrl: control-unit requests, stall and load return,
// and the registered request/ready handshake toward the variable-latency data memory.
interface data_mem_ctrl_if;
  logic       READ_REQ;
  logic       WRITE_REQ;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic       BUSYWAIT;
  logic [7:0] READDATA;
  logic       LOAD_WE;
  logic       MEM_READ;
  logic       MEM_WRITE;
  logic [7:0] MEM_ADDRESS;
  logic [7:0] MEM_WRITEDATA;
  logic [7:0] MEM_READDATA;
  logic       MEM_READY;
  logic       MEM_ERROR;

  modport slave (
    input  READ_REQ, WRITE_REQ, ADDRESS, WRITEDATA, MEM_READDATA, MEM_READY,
    output BUSYWAIT, READDATA, LOAD_WE, MEM_READ, MEM_WRITE, MEM_ADDRESS,
           MEM_WRITEDATA, MEM_ERROR
  );

  modport master (
    output READ_REQ, WRITE_REQ, ADDRESS, WRITEDATA, MEM_READDATA, MEM_READY,
    input  BUSYWAIT, READDATA, LOAD_WE, MEM_READ, MEM_WRITE, MEM_ADDRESS,
           MEM_WRITEDATA, MEM_ERROR
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer stalling the 8-bit core with BUSYWAIT until data memory answers.
// Optional access timeout with sticky MEM_ERROR is enabled by defining DATA_MEM_TIMEOUT_EN.
module data_mem_ctrl #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic           CLK,
  input  logic           RESET,
  data_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] rdata_q, rdata_d;
  logic       load_we_q, load_we_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;

`ifdef DATA_MEM_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.MEM_ERROR = err_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT;
  assign bus.MEM_ERROR    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      rdata_q     <= 8'h00;
      load_we_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      load_we_q   <= load_we_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    load_we_d   = 1'b0;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
`ifdef DATA_MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef DATA_MEM_TIMEOUT_EN
        cnt_d = 8'd0;
`endif
        // A read wins over a simultaneous write; the write is dropped.
        if (bus.READ_REQ) begin
          addr_d     = bus.ADDRESS;
          mem_read_d = 1'b1;
          state_d    = READ;
        end else if (bus.WRITE_REQ) begin
          addr_d      = bus.ADDRESS;
          wdata_d     = bus.WRITEDATA;
          mem_write_d = 1'b1;
          state_d     = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      READ, WRITE: begin
        if (bus.MEM_READY) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = DONE;
          if (state_q == READ) begin
            rdata_d   = bus.MEM_READDATA;
            load_we_d = 1'b1;
          end else begin
            load_we_d = 1'b0;
          end
        end else begin
`ifdef DATA_MEM_TIMEOUT_EN
          // Abort on the cycle the count would reach TIMEOUT: TIMEOUT cycles spent waiting.
          if (cnt_q == TIMEOUT - 8'd1) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            err_d       = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
`else
          state_d = state_q;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.BUSYWAIT      = (state_q == READ) || (state_q == WRITE) ||
                             ((state_q == IDLE) && (bus.READ_REQ || bus.WRITE_REQ));
  assign bus.READDATA      = rdata_q;
  assign bus.LOAD_WE       = load_we_q;
  assign bus.MEM_READ      = mem_read_q;
  assign bus.MEM_WRITE     = mem_write_q;
  assign bus.MEM_ADDRESS   = addr_q;
  assign bus.MEM_WRITEDATA = wdata_q;

endmodule
